// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM transmit chain: symbol geometry, pilot-polarity
// sequence length, scheduler state encoding and the Q1.15 +1/-1 pilot values
// used by the pilot inserter.
package ofdm_tx_pkg;

  localparam int unsigned N_DAT   = 48;   // data words per OFDM symbol
  localparam int unsigned PIL_MOD = 127;  // pilot-polarity sequence length

  // Q1.15 +1 and -1 pilot amplitudes.
  localparam logic [15:0] PIL_POS = 16'h7fff;
  localparam logic [15:0] PIL_NEG = 16'h8001;

  typedef enum logic [1:0] {
    StIdle,
    StSym,
    StGap,
    StDone
  } sym_state_e;

  // Next pilot-polarity index, wrapping at the end of the sequence.
  function automatic logic [6:0] pil_next(input logic [6:0] idx);
    return (idx == 7'(PIL_MOD - 1)) ? 7'd0 : idx + 7'd1;
  endfunction

endpackage

// File: rtl/ofdm_sym_sched_if.sv
// Word-oriented bus link between stages of the OFDM transmit chain.
//   cyc/stb/we/dat : driven by the master
//   ack            : driven by the slave, word accepted this cycle
interface ofdm_sym_sched_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] dat;
  logic        ack;

  modport master (output cyc, output stb, output we, output dat, input ack);
  modport slave  (input cyc, input stb, input we, input dat, output ack);
endinterface

// File: rtl/wb_out_reg.sv
// Single-entry output register with STB/ACK handshake.
//   load_i  : capture dat_i and raise stb_o
//   ack_i   : downstream accept; drops stb_o unless a new word loads
//   flush_i : discard any held word
//   stb_o/dat_o : registered word toward the downstream stage
module wb_out_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [Width-1:0] dat_i,
  input  logic             ack_i,
  output logic             stb_o,
  output logic [Width-1:0] dat_o
);

  logic             stb_d, stb_q;
  logic [Width-1:0] dat_d, dat_q;

  always_comb begin
    stb_d = stb_q;
    dat_d = dat_q;
    if (flush_i) begin
      stb_d = 1'b0;
    end else if (load_i) begin
      // Load wins over a same-cycle ack so the stage streams at full rate.
      stb_d = 1'b1;
      dat_d = dat_i;
    end else if (stb_q && ack_i) begin
      stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q <= 1'b0;
      dat_q <= '0;
    end else begin
      stb_q <= stb_d;
      dat_q <= dat_d;
    end
  end

  assign stb_o = stb_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/ofdm_sym_sched.sv
// OFDM transmit symbol scheduler. Cuts the mapped-subcarrier stream into symbols
// of N_DAT words, each framed by its own downstream CYC window, separated by GAP
// idle cycles. Tracks symbols completed and the pilot-polarity index.
//   CLK_I, RST_I (async, active-low)
//   START_I/SYM_NUM_I : frame start and data-symbol count (IDLE only)
//   ABORT_I           : synchronous abort, any state
//   up_if (slave)     : upstream words from the subcarrier mapper
//   dn_if (master)    : downstream words to the pilot inserter (WE = STB)
//   PIL_IDX_O, SYM_CNT_O, BUSY_O, DONE_O : status
module ofdm_sym_sched
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned GAP       = 4,   // 2..15
  parameter int unsigned SYM_W     = 12,
  parameter int unsigned PIL_START = 1
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 START_I,
  input  logic                 ABORT_I,
  input  logic [SYM_W-1:0]     SYM_NUM_I,
  ofdm_sym_sched_if.slave      up_if,
  ofdm_sym_sched_if.master     dn_if,
  output logic [6:0]           PIL_IDX_O,
  output logic [SYM_W-1:0]     SYM_CNT_O,
  output logic                 BUSY_O,
  output logic                 DONE_O
);

  sym_state_e       state_d, state_q;
  logic [SYM_W-1:0] sym_num_d, sym_num_q;
  logic [SYM_W-1:0] sym_cnt_d, sym_cnt_q;
  logic [6:0]       pil_idx_d, pil_idx_q;
  logic [5:0]       acc_cnt_d, acc_cnt_q;
  logic [5:0]       ack_cnt_d, ack_cnt_q;
  logic [3:0]       gap_cnt_d, gap_cnt_q;
  logic             done_d, done_q;

  logic        stb;
  logic [31:0] dat;
  logic        ena;
  logic        up_ack;
  logic        dn_hs;
  logic        sym_end;

  assign ena = up_if.cyc & up_if.stb & up_if.we;

  // Accept only when the output register is free or draining this cycle.
  // Gated by ABORT_I so no word is taken that would be discarded anyway.
  assign up_ack = ena && (state_q == StSym) && (acc_cnt_q < 6'(N_DAT)) &&
                  (!stb || dn_if.ack) && !ABORT_I;

  assign dn_hs   = stb & dn_if.ack;
  assign sym_end = (state_q == StSym) && dn_hs && (ack_cnt_q == 6'(N_DAT - 1));

  always_comb begin
    state_d   = state_q;
    sym_num_d = sym_num_q;
    sym_cnt_d = sym_cnt_q;
    pil_idx_d = pil_idx_q;
    acc_cnt_d = acc_cnt_q;
    ack_cnt_d = ack_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;

    if (ABORT_I) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START_I) begin
            sym_num_d = SYM_NUM_I;
            sym_cnt_d = '0;
            pil_idx_d = 7'(PIL_START);
            acc_cnt_d = '0;
            ack_cnt_d = '0;
            state_d   = (SYM_NUM_I == '0) ? StDone : StSym;
          end
        end
        StSym: begin
          if (up_ack) acc_cnt_d = acc_cnt_q + 6'd1;
          if (dn_hs)  ack_cnt_d = ack_cnt_q + 6'd1;
          if (sym_end) begin
            sym_cnt_d = sym_cnt_q + SYM_W'(1);
            pil_idx_d = pil_next(pil_idx_q);
            gap_cnt_d = '0;
            state_d   = (sym_cnt_q + SYM_W'(1) == sym_num_q) ? StDone : StGap;
          end
        end
        StGap: begin
          gap_cnt_d = gap_cnt_q + 4'd1;
          if (gap_cnt_q == 4'(GAP - 1)) begin
            acc_cnt_d = '0;
            ack_cnt_d = '0;
            state_d   = StSym;
          end
        end
        StDone: begin
          // DONE_O is registered so it coincides with BUSY_O falling.
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= StIdle;
      sym_num_q <= '0;
      sym_cnt_q <= '0;
      pil_idx_q <= '0;
      acc_cnt_q <= '0;
      ack_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_num_q <= sym_num_d;
      sym_cnt_q <= sym_cnt_d;
      pil_idx_q <= pil_idx_d;
      acc_cnt_q <= acc_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  wb_out_reg #(
    .Width (32)
  ) u_out_reg (
    .clk_i   (CLK_I),
    .rst_ni  (RST_I),
    .flush_i (ABORT_I),
    .load_i  (up_ack),
    .dat_i   (up_if.dat),
    .ack_i   (dn_if.ack),
    .stb_o   (stb),
    .dat_o   (dat)
  );

  assign up_if.ack = up_ack;
  assign dn_if.cyc = (state_q == StSym);
  assign dn_if.stb = stb;
  assign dn_if.we  = stb;
  assign dn_if.dat = dat;

  assign PIL_IDX_O = pil_idx_q;
  assign SYM_CNT_O = sym_cnt_q;
  assign BUSY_O    = (state_q != StIdle);
  assign DONE_O    = done_q;

endmodule

// File: tb/tb_ofdm_sym_sched.sv
module tb_ofdm_sym_sched;
  import ofdm_tx_pkg::*;

  localparam int unsigned GAP_C = 4;
  localparam int unsigned SYM_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [SYM_W-1:0] sym_num = '0;
  logic [6:0]       pil_a, pil_b;
  logic [SYM_W-1:0] cnt_a, cnt_b;
  logic             busy_a, busy_b, done_a, done_b;

  ofdm_sym_sched_if up ();
  ofdm_sym_sched_if dn ();
  ofdm_sym_sched_if up_b ();
  ofdm_sym_sched_if dn_b ();

  // Second instance sees identical stimulus; only its pilot start differs.
  assign up_b.cyc = up.cyc;
  assign up_b.stb = up.stb;
  assign up_b.we  = up.we;
  assign up_b.dat = up.dat;
  assign dn_b.ack = dn.ack;

  ofdm_sym_sched #(.GAP(GAP_C), .SYM_W(SYM_W), .PIL_START(1)) dut (
    .CLK_I(clk), .RST_I(rst_n), .START_I(start), .ABORT_I(abort), .SYM_NUM_I(sym_num),
    .up_if(up), .dn_if(dn), .PIL_IDX_O(pil_a), .SYM_CNT_O(cnt_a), .BUSY_O(busy_a),
    .DONE_O(done_a)
  );

  ofdm_sym_sched #(.GAP(GAP_C), .SYM_W(SYM_W), .PIL_START(125)) dut_b (
    .CLK_I(clk), .RST_I(rst_n), .START_I(start), .ABORT_I(abort), .SYM_NUM_I(sym_num),
    .up_if(up_b), .dn_if(dn_b), .PIL_IDX_O(pil_b), .SYM_CNT_O(cnt_b), .BUSY_O(busy_b),
    .DONE_O(done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] exp_q[$];
  int frame_syms = 0;
  int syms_done = 0;
  int win_words = 0;
  int win_len = 0;
  int last_win_len = 0;
  int low_len = 0;
  int done_seen = 0;
  int total_out = 0;
  bit aborted = 1'b0;
  bit cyc_prev = 1'b0;

  // Driver controls
  bit stb_en = 1'b1;
  bit ack_rand = 1'b0;
  bit took = 1'b0;

  // Upstream source and downstream acceptor; every accepted word is expected
  // downstream in the same order.
  initial begin
    up.cyc = 1'b1;
    up.we  = 1'b1;
    up.stb = 1'b0;
    up.dat = $urandom;
    dn.ack = 1'b0;
    forever begin
      @(negedge clk);
      took = (up.ack === 1'b1);
      if (took) exp_q.push_back(up.dat);
      @(posedge clk);
      #1;
      if (took) up.dat = $urandom;
      up.stb = stb_en;
      dn.ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each downstream transfer and checks symbol
  // framing, counters and pilot index against the frame model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc_prev = 1'b0;
      end else begin
        if (dn.cyc && !cyc_prev) begin
          if (!aborted) begin
            chk("pil_a_at_sym_start", 64'(pil_a), 64'((1 + syms_done) % PIL_MOD));
            chk("pil_b_at_sym_start", 64'(pil_b), 64'((125 + syms_done) % PIL_MOD));
            chk("sym_within_frame", 64'(syms_done < frame_syms), 64'd1);
            if (syms_done > 0) chk("gap_min_len", 64'(low_len >= GAP_C), 64'd1);
          end
          win_words = 0;
          win_len = 0;
        end
        if (dn.stb && dn.ack) begin
          if (exp_q.size() == 0) chk("dn_word_expected", 64'd0, 64'd1);
          else chk("dn_dat", 64'(dn.dat), 64'(exp_q.pop_front()));
          win_words++;
          total_out++;
        end
        if (dn.cyc) win_len++;
        if (!dn.cyc && cyc_prev) begin
          if (!aborted) begin
            syms_done++;
            chk("words_per_sym", 64'(win_words), 64'(N_DAT));
            chk("sym_cnt_a_at_end", 64'(cnt_a), 64'(syms_done));
            chk("sym_cnt_b_at_end", 64'(cnt_b), 64'(syms_done));
            chk("pil_a_at_end", 64'(pil_a), 64'((1 + syms_done) % PIL_MOD));
            chk("pil_b_at_end", 64'(pil_b), 64'((125 + syms_done) % PIL_MOD));
            last_win_len = win_len;
          end
          low_len = 0;
        end
        if (!dn.cyc) low_len++;
        if (done_a) begin
          done_seen++;
          chk("done_sym_cnt", 64'(cnt_a), 64'(frame_syms));
          chk("done_busy_low", 64'(busy_a), 64'd0);
          chk("done_b_pulse", 64'(done_b), 64'd1);
          chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
        end
        cyc_prev = dn.cyc;
      end
    end
  end

  task automatic start_frame(input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    sym_num = SYM_W'(n);
    frame_syms = n;
    syms_done = 0;
    aborted = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_seen;
    int i = 0;
    while (done_seen == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("done_within_budget", 64'(done_seen != d0), 64'd1);
  endtask

  task automatic wait_words(input int syms, input int words, input int budget);
    int i = 0;
    while (!(syms_done == syms && win_words >= words) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("reached_word_point", 64'(i < budget), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int w0;
    int d0;

    // Reset, then idle with upstream valid: nothing may move.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_outputs", {7'd0, dn.cyc, dn.stb, dn.we, up.ack, busy_a, done_a, pil_a, cnt_a,
          dn.dat}, 64'd0);
    end

    // Single symbol, full rate.
    w0 = total_out;
    d0 = done_seen;
    start_frame(1);
    wait_done(400);
    repeat (5) @(negedge clk);
    chk("t1_words", 64'(total_out - w0), 64'd48);
    chk("t1_cyc_high_len", 64'(last_win_len), 64'd49);
    chk("t1_done_once", 64'(done_seen - d0), 64'd1);
    chk("t1_sym_cnt", 64'(cnt_a), 64'd1);
    chk("t1_pil_a", 64'(pil_a), 64'd2);
    chk("t1_pil_b", 64'(pil_b), 64'd126);

    // Three symbols with random downstream backpressure.
    ack_rand = 1'b1;
    w0 = total_out;
    start_frame(3);
    wait_done(3000);
    chk("t2_words", 64'(total_out - w0), 64'd144);
    chk("t2_sym_cnt", 64'(cnt_a), 64'd3);

    // Upstream stall mid-symbol.
    ack_rand = 1'b0;
    start_frame(1);
    wait_words(0, 20, 200);
    stb_en = 1'b0;
    repeat (2) @(negedge clk);
    repeat (8) begin
      @(negedge clk);
      chk("stall_cyc_hi_stb_lo", 64'({dn.cyc, dn.stb}), 64'b10);
    end
    stb_en = 1'b1;
    wait_done(400);
    chk("t3_sym_cnt", 64'(cnt_a), 64'd1);

    // Pilot index wrap (second instance starts at 125).
    ack_rand = 1'b1;
    start_frame(4);
    wait_done(4000);
    chk("t4_pil_b_final", 64'(pil_b), 64'd2);
    chk("t4_pil_a_final", 64'(pil_a), 64'd5);
    chk("t4_sym_cnt", 64'(cnt_a), 64'd4);

    // Abort at word 20 of the second symbol.
    ack_rand = 1'b0;
    start_frame(3);
    wait_words(1, 20, 400);
    @(posedge clk);
    #1;
    aborted = 1'b1;
    abort = 1'b1;
    d0 = done_seen;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_outs_low", 64'({dn.cyc, dn.stb, up.ack, busy_a}), 64'd0);
    chk("abort_sym_cnt", 64'(cnt_a), 64'd1);
    repeat (6) @(negedge clk);
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);
    exp_q.delete();
    start_frame(1);
    wait_done(400);
    chk("after_abort_sym_cnt", 64'(cnt_a), 64'd1);

    // Zero-symbol frame: DONE_O at cycle 2, CYC_O never rises.
    @(posedge clk);
    #1;
    start = 1'b1;
    sym_num = '0;
    frame_syms = 0;
    syms_done = 0;
    aborted = 1'b0;
    d0 = done_seen;
    @(negedge clk);
    chk("z_c0_busy_done_cyc", 64'({busy_a, done_a, dn.cyc}), 64'b000);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("z_c1_busy_done_cyc", 64'({busy_a, done_a, dn.cyc}), 64'b100);
    @(negedge clk);
    chk("z_c2_busy_done_cyc", 64'({busy_a, done_a, dn.cyc}), 64'b010);
    @(negedge clk);
    chk("z_c3_busy_done_cyc", 64'({busy_a, done_a, dn.cyc}), 64'b000);
    chk("z_done_once", 64'(done_seen - d0), 64'd1);

    // START_I held high through a running frame has no effect.
    start_frame(2);
    @(posedge clk);
    #1;
    start = 1'b1;
    sym_num = SYM_W'(5);
    begin
      int i = 0;
      while (syms_done < 2 && i < 400) begin
        @(negedge clk);
        i++;
      end
      chk("held_start_reached_end", 64'(i < 400), 64'd1);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20);
    chk("held_start_sym_cnt", 64'(cnt_a), 64'd2);
    repeat (10) @(negedge clk);
    chk("held_start_idle", 64'(busy_a), 64'd0);

    // Asynchronous reset mid-symbol.
    start_frame(2);
    wait_words(0, 10, 200);
    #2;
    aborted = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 64'({dn.cyc, dn.stb, up.ack, busy_a, pil_a, cnt_a}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 64'({busy_a, dn.cyc}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
